// File: rtl/mod_step_counter.sv
// mod_step_counter: modulo/saturating up-down counter with variable step, clear/load,
// registered boundary pulse and sticky overflow flag.
module mod_step_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             boundary,
  output logic             overflow_sticky
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
  logic [WIDTH-1:0] count_q, count_d;
  logic             boundary_q, boundary_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH:0]   cw, lv, st, s, sum, nxt_up, nxt_dn, nxt, ld;
  logic             over_up, under_dn, hit;
  // One extra bit keeps sums and the wrapped-down value exact before range compare.
  always_comb begin
    cw       = {1'b0, count_q};
    lv       = {1'b0, load_value};
    st       = {1'b0, step};
    s        = st > MAX ? MAX : st;
    ld       = lv > MAX ? MAX : lv;
    sum      = cw + s;
    over_up  = sum > MAX;
    under_dn = s > cw;
    nxt_up   = over_up ? (SATURATE ? MAX : sum - MOD) : sum;
    nxt_dn   = under_dn ? (SATURATE ? '0 : cw + MOD - s) : cw - s;
    nxt      = up ? nxt_up : nxt_dn;
    hit      = up ? over_up : under_dn;
    count_d    = clear ? '0 : load ? ld[WIDTH-1:0] : enable ? nxt[WIDTH-1:0] : count_q;
    boundary_d = !clear && !load && enable && hit;
    sticky_d   = !clear && (sticky_q || boundary_d);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      boundary_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      boundary_q <= boundary_d;
      sticky_q   <= sticky_d;
    end
  end
  assign count           = count_q;
  assign boundary        = boundary_q;
  assign overflow_sticky = sticky_q;
endmodule

// File: tb/tb_mod_step_counter.sv
// tb_mod_step_counter: three counter variants (wrap/10, saturate/10, wrap/16) driven in
// lockstep and compared against an integer reference model.
module tb_mod_step_counter;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, clear = 1'b0, load = 1'b0, up = 1'b1;
  logic [3:0] load_value = '0, step = '0;
  logic [3:0] cnt [3];
  logic       bnd [3];
  logic       stk [3];
  int mc [3], mb [3], ms [3];
  int vecs = 0, errs = 0;
  localparam int M [3] = '{10, 10, 16};
  localparam int S [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  mod_step_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up(up), .step(step),
    .count(cnt[0]), .boundary(bnd[0]), .overflow_sticky(stk[0]));
  mod_step_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up(up), .step(step),
    .count(cnt[1]), .boundary(bnd[1]), .overflow_sticky(stk[1]));
  mod_step_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up(up), .step(step),
    .count(cnt[2]), .boundary(bnd[2]), .overflow_sticky(stk[2]));

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; mb[i] = 0; ms[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int lim, s;
      lim = M[i] - 1;
      s = (int'(step) > lim) ? lim : int'(step);
      if (clear) begin
        mc[i] = 0; mb[i] = 0; ms[i] = 0;
      end else if (load) begin
        mc[i] = (int'(load_value) > lim) ? lim : int'(load_value);
        mb[i] = 0;
      end else if (enable) begin
        if (up) begin
          if (mc[i] + s <= lim) begin
            mc[i] = mc[i] + s; mb[i] = 0;
          end else begin
            mc[i] = S[i] ? lim : mc[i] + s - M[i]; mb[i] = 1; ms[i] = 1;
          end
        end else begin
          if (s <= mc[i]) begin
            mc[i] = mc[i] - s; mb[i] = 0;
          end else begin
            mc[i] = S[i] ? 0 : mc[i] + M[i] - s; mb[i] = 1; ms[i] = 1;
          end
        end
      end else begin
        mb[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      assert (int'(cnt[i]) === mc[i]) else begin
        errs++;
        $error("FAIL %s count[%0d] got %0d expected %0d", tag, i, cnt[i], mc[i]);
      end
      vecs++;
      assert (int'(bnd[i]) === mb[i]) else begin
        errs++;
        $error("FAIL %s boundary[%0d] got %0d expected %0d", tag, i, bnd[i], mb[i]);
      end
      vecs++;
      assert (int'(stk[i]) === ms[i]) else begin
        errs++;
        $error("FAIL %s sticky[%0d] got %0d expected %0d", tag, i, stk[i], ms[i]);
      end
    end
  endtask

  task automatic set_in(input logic e, input logic c, input logic l, input logic u,
                        input logic [3:0] lv, input logic [3:0] st);
    enable = e; clear = c; load = l; up = u; load_value = lv; step = st;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all(tag);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 check_all("por");
    #2 reset = 1'b1;
    set_in(0, 0, 1, 1, 4'd7, 4'd0); cyc("load7");
    set_in(0, 0, 0, 1, 4'd0, 4'd0);
    async_reset("async_rst");
    set_in(0, 0, 1, 1, 4'd8, 4'd0); cyc("load8");
    set_in(1, 0, 0, 1, 4'd0, 4'd3); cyc("wrap_up");
    cyc("wrap_up2");
    set_in(0, 0, 1, 1, 4'd2, 4'd0); cyc("load2");
    set_in(1, 0, 0, 0, 4'd0, 4'd5); cyc("wrap_dn");
    set_in(1, 0, 0, 0, 4'd0, 4'd15); cyc("wrap_dn_clamp");
    set_in(0, 0, 1, 1, 4'd8, 4'd0); cyc("load8b");
    set_in(1, 0, 0, 1, 4'd0, 4'd3); cyc("sat_up");
    cyc("sat_hold1");
    cyc("sat_hold2");
    set_in(0, 0, 1, 1, 4'd2, 4'd0); cyc("load2b");
    set_in(1, 0, 0, 0, 4'd0, 4'd4); cyc("sat_dn");
    set_in(1, 1, 1, 1, 4'd5, 4'd1); cyc("prio_clear");
    set_in(1, 0, 1, 1, 4'd12, 4'd1); cyc("prio_load");
    set_in(0, 0, 0, 1, 4'd0, 4'd3);
    repeat (5) cyc("hold");
    set_in(1, 0, 0, 1, 4'd0, 4'd0);
    repeat (3) cyc("zero_step");
    set_in(0, 0, 1, 1, 4'd15, 4'd0); cyc("load15");
    set_in(1, 0, 0, 1, 4'd0, 4'd1); cyc("mod16_wrap");
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(3) != 0, $urandom_range(31) == 0, $urandom_range(7) == 0,
             1'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(49) == 0) async_reset("rand_rst");
      else cyc("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
